// File: rtl/stack_pkg.sv
// Shared encodings and defaults for the stack-pointer sequencer.
package stack_pkg;

  localparam int unsigned SP_W = 16;
  localparam int unsigned SEL_W = 2;

  localparam logic [SP_W-1:0] SP_RESET_DEF = 16'hFFFF;
  localparam logic [SP_W-1:0] SP_LIMIT_DEF = 16'hFE00;

  localparam logic [SEL_W-1:0] WRSEL_ALU   = 2'd0;
  localparam logic [SEL_W-1:0] WRSEL_PC    = 2'd1;
  localparam logic [SEL_W-1:0] WRSEL_FLAGS = 2'd2;

  localparam logic [SEL_W-1:0] RDDST_GPR   = 2'd0;
  localparam logic [SEL_W-1:0] RDDST_PC    = 2'd1;
  localparam logic [SEL_W-1:0] RDDST_FLAGS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALL2 = 2'd1,
    ST_RET2  = 2'd2
  } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Stack pointer owner: turns push/pop/call/ret requests into data-memory
// strobes, sequences two-word call/ret frames and flags region violations.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter logic [SP_W-1:0] SP_RESET = SP_RESET_DEF,
  parameter logic [SP_W-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic             call_req,
  input  logic             ret_req,
  input  logic             sp_load,
  input  logic [SP_W-1:0]  sp_load_val,
  input  logic             err_clr,
  output logic             ready,
  output logic [SP_W-1:0]  sp,
  output logic             push,
  output logic             pop,
  output logic [SEL_W-1:0] wr_sel,
  output logic             rd_valid,
  output logic [SEL_W-1:0] rd_dst,
  output logic [SP_W-1:0]  sp_cur,
  output logic [SP_W-1:0]  depth,
  output logic             overflow,
  output logic             underflow,
  output logic             load_err
);

  localparam int unsigned EW = SP_W + 1;

  state_t state_q, state_d;

  logic [EW-1:0]    free_w;
  logic [SP_W-1:0]  used_w;
  logic             can_push, can_call, can_pop, can_ret, load_ok;

  logic [SP_W-1:0]  sp_cur_d, addr_d, sp_d;
  logic             push_d, pop_d;
  logic [SEL_W-1:0] wr_sel_d, pop_dst_d, pop_dst_q;
  logic             set_ovf, set_unf, set_lerr;

  // Region arithmetic is one bit wider so SP_LIMIT-1 and free count never wrap.
  always_comb begin
    free_w   = (sp_cur >= SP_LIMIT) ? (EW'(sp_cur) - EW'(SP_LIMIT) + EW'(1)) : '0;
    used_w   = SP_RESET - sp_cur;
    can_push = free_w >= EW'(1);
    can_call = free_w >= EW'(2);
    can_pop  = used_w >= SP_W'(1);
    can_ret  = used_w >= SP_W'(2);
    load_ok  = (EW'(sp_load_val) + EW'(1) >= EW'(SP_LIMIT)) && (sp_load_val <= SP_RESET);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!sp_load && call_req && can_call)                 state_d = ST_CALL2;
        else if (!sp_load && !call_req && ret_req && can_ret) state_d = ST_RET2;
      end
      ST_CALL2: state_d = ST_IDLE;
      ST_RET2:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // One request per idle cycle, in priority order; the rest are dropped.
  always_comb begin
    sp_cur_d  = sp_cur;
    addr_d    = sp_cur;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    wr_sel_d  = WRSEL_ALU;
    pop_dst_d = RDDST_GPR;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    set_lerr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sp_load) begin
          if (load_ok) sp_cur_d = sp_load_val;
          else         set_lerr = 1'b1;
        end else if (call_req) begin
          if (can_call) begin
            push_d   = 1'b1;
            wr_sel_d = WRSEL_PC;
            sp_cur_d = sp_cur - SP_W'(1);
          end else set_ovf = 1'b1;
        end else if (ret_req) begin
          if (can_ret) begin
            pop_d     = 1'b1;
            pop_dst_d = RDDST_FLAGS;
            addr_d    = sp_cur + SP_W'(1);
            sp_cur_d  = sp_cur + SP_W'(1);
          end else set_unf = 1'b1;
        end else if (push_req) begin
          if (can_push) begin
            push_d   = 1'b1;
            sp_cur_d = sp_cur - SP_W'(1);
          end else set_ovf = 1'b1;
        end else if (pop_req) begin
          if (can_pop) begin
            pop_d    = 1'b1;
            addr_d   = sp_cur + SP_W'(1);
            sp_cur_d = sp_cur + SP_W'(1);
          end else set_unf = 1'b1;
        end
      end
      ST_CALL2: begin
        push_d   = 1'b1;
        wr_sel_d = WRSEL_FLAGS;
        sp_cur_d = sp_cur - SP_W'(1);
      end
      ST_RET2: begin
        pop_d     = 1'b1;
        pop_dst_d = RDDST_PC;
        addr_d    = sp_cur + SP_W'(1);
        sp_cur_d  = sp_cur + SP_W'(1);
      end
      default: ;
    endcase
    sp_d = (push_d || pop_d) ? addr_d : sp_cur_d;
  end

  // Registered outputs; read tag trails the pop strobe by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_cur    <= SP_RESET;
      sp        <= SP_RESET;
      depth     <= '0;
      push      <= 1'b0;
      pop       <= 1'b0;
      wr_sel    <= WRSEL_ALU;
      pop_dst_q <= RDDST_GPR;
      rd_valid  <= 1'b0;
      rd_dst    <= RDDST_GPR;
      ready     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sp_cur    <= sp_cur_d;
      sp        <= sp_d;
      depth     <= SP_RESET - sp_cur_d;
      push      <= push_d;
      pop       <= pop_d;
      wr_sel    <= wr_sel_d;
      pop_dst_q <= pop_dst_d;
      rd_valid  <= pop;
      rd_dst    <= pop ? pop_dst_q : RDDST_GPR;
      ready     <= (state_d == ST_IDLE);
      overflow  <= (overflow  & ~err_clr) | set_ovf;
      underflow <= (underflow & ~err_clr) | set_unf;
      load_err  <= (load_err  & ~err_clr) | set_lerr;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl against a frame-queue reference model.
module tb_stack_ctrl;

  localparam int RST_V = 16'hFFFF;
  localparam int LIM_V = 16'hFFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_req = 1'b0, pop_req = 1'b0, call_req = 1'b0, ret_req = 1'b0;
  logic        sp_load = 1'b0, err_clr = 1'b0;
  logic [15:0] sp_load_val = '0;
  logic        ready, push, pop, rd_valid, overflow, underflow, load_err;
  logic [15:0] sp, sp_cur, depth;
  logic [1:0]  wr_sel, rd_dst;

  stack_ctrl #(.SP_RESET(16'hFFFF), .SP_LIMIT(16'hFFFC)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req),
    .call_req(call_req), .ret_req(ret_req), .sp_load(sp_load),
    .sp_load_val(sp_load_val), .err_clr(err_clr), .ready(ready), .sp(sp),
    .push(push), .pop(pop), .wr_sel(wr_sel), .rd_valid(rd_valid),
    .rd_dst(rd_dst), .sp_cur(sp_cur), .depth(depth), .overflow(overflow),
    .underflow(underflow), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a queue of pending memory micro-ops; a frame enqueues both words.
  typedef struct { bit is_push; int tag; } op_t;
  op_t plan[$];
  int  m_sp = RST_V;
  bit  m_ovf, m_unf, m_lerr;
  bit  e_push, e_pop, e_rdv, e_ready;
  int  e_sp, e_wrsel, e_rdd, e_popdst;

  task automatic model_step();
    int free_n, used_n, v;
    bit s_ovf, s_unf, s_lerr;
    op_t op;
    if (rst) begin
      plan.delete();
      m_sp = RST_V; m_ovf = 0; m_unf = 0; m_lerr = 0;
      e_push = 0; e_pop = 0; e_rdv = 0; e_rdd = 0; e_sp = RST_V;
      e_wrsel = 0; e_popdst = 0; e_ready = 1;
      return;
    end
    e_rdv = e_pop;
    e_rdd = e_pop ? e_popdst : 0;
    s_ovf = 0; s_unf = 0; s_lerr = 0;
    free_n = (m_sp >= LIM_V) ? m_sp - LIM_V + 1 : 0;
    used_n = RST_V - m_sp;
    v = int'(sp_load_val);
    if (plan.size() == 0) begin
      if (sp_load) begin
        if (v >= LIM_V - 1 && v <= RST_V) m_sp = v; else s_lerr = 1;
      end else if (call_req) begin
        if (free_n >= 2) begin
          plan.push_back('{1'b1, 1}); plan.push_back('{1'b1, 2});
        end else s_ovf = 1;
      end else if (ret_req) begin
        if (used_n >= 2) begin
          plan.push_back('{1'b0, 2}); plan.push_back('{1'b0, 1});
        end else s_unf = 1;
      end else if (push_req) begin
        if (free_n >= 1) plan.push_back('{1'b1, 0}); else s_ovf = 1;
      end else if (pop_req) begin
        if (used_n >= 1) plan.push_back('{1'b0, 0}); else s_unf = 1;
      end
    end
    m_ovf  = (m_ovf  && !err_clr) || s_ovf;
    m_unf  = (m_unf  && !err_clr) || s_unf;
    m_lerr = (m_lerr && !err_clr) || s_lerr;
    e_push = 0; e_pop = 0; e_wrsel = 0;
    if (plan.size() > 0) begin
      op = plan.pop_front();
      if (op.is_push) begin
        e_push = 1; e_wrsel = op.tag; e_sp = m_sp; m_sp = m_sp - 1;
      end else begin
        e_pop = 1; e_popdst = op.tag; m_sp = m_sp + 1; e_sp = m_sp;
      end
    end else begin
      e_sp = m_sp;
    end
    e_ready = (plan.size() == 0);
  endtask

  task automatic compare_all();
    check("ready",     16'(ready),     16'(e_ready));
    check("sp",        sp,             16'(e_sp));
    check("push",      16'(push),      16'(e_push));
    check("pop",       16'(pop),       16'(e_pop));
    check("wr_sel",    16'(wr_sel),    16'(e_wrsel));
    check("rd_valid",  16'(rd_valid),  16'(e_rdv));
    check("rd_dst",    16'(rd_dst),    16'(e_rdd));
    check("sp_cur",    sp_cur,         16'(m_sp));
    check("depth",     depth,          16'(RST_V - m_sp));
    check("overflow",  16'(overflow),  16'(m_ovf));
    check("underflow", 16'(underflow), 16'(m_unf));
    check("load_err",  16'(load_err),  16'(m_lerr));
  endtask

  // One clock: drive at negedge, advance model at posedge, sample 1 after.
  task automatic step(input bit r, input bit pu, input bit po, input bit ca,
                      input bit re, input bit ld, input logic [15:0] val, input bit clr);
    @(negedge clk);
    rst = r; push_req = pu; pop_req = po; call_req = ca; ret_req = re;
    sp_load = ld; sp_load_val = val; err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 16'h0, 0); endtask
  task automatic do_rst(); step(1, 0, 0, 0, 0, 0, 16'h0, 0); endtask

  initial begin
    // Directed scenarios
    do_rst(); step(0, 1, 0, 0, 0, 0, 16'h0, 0); idle();
    step(0, 1, 0, 0, 0, 0, 16'h0, 0); step(0, 1, 0, 0, 0, 0, 16'h0, 0);
    step(0, 0, 1, 0, 0, 0, 16'h0, 0); idle(); idle();
    do_rst(); step(0, 0, 0, 1, 0, 0, 16'h0, 0); idle(); idle();
    step(0, 0, 0, 0, 1, 0, 16'h0, 0); idle(); idle(); idle();
    do_rst();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 16'h0, 0);
    step(0, 1, 0, 0, 0, 0, 16'h0, 0); idle();
    step(0, 0, 0, 0, 0, 1, 16'hFFFC, 0); step(0, 0, 0, 1, 0, 0, 16'h0, 0); idle();
    step(0, 0, 0, 0, 0, 0, 16'h0, 1); idle();
    step(0, 0, 0, 0, 0, 1, 16'hFFFB, 0); step(0, 0, 0, 0, 0, 1, 16'hFFFA, 0);
    do_rst(); step(0, 0, 0, 0, 1, 0, 16'h0, 0); step(0, 1, 0, 0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0, 0); step(0, 0, 0, 0, 0, 1, 16'h1000, 0); idle();
    step(0, 0, 0, 0, 0, 0, 16'h0, 1); step(0, 0, 1, 0, 0, 0, 16'h0, 1);
    do_rst(); step(0, 1, 1, 1, 0, 0, 16'h0, 0); do_rst(); idle(); idle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] val;
      val = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(16'hFFF9, 16'hFFFF));
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11) == 0, val,
           $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
